// File: rtl/sobol_rng_nd_if.sv
// Control, direction-vector load and point output bundle for sobol_rng_nd.
// The master side (SNG controller or bench) drives the controls; the generator is the slave.
interface sobol_rng_nd_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NDIM  = 2
);
    localparam int unsigned IDXW = $clog2(WIDTH);
    localparam int unsigned DIMW = (NDIM > 1) ? $clog2(NDIM) : 1;

    logic                    enable;
    logic                    clear;
    logic                    dv_we;
    logic [DIMW-1:0]         dv_dim;
    logic [IDXW-1:0]         dv_idx;
    logic [WIDTH-1:0]        dv_data;
    logic [NDIM*WIDTH-1:0]   rng_out;
    logic [WIDTH-1:0]        cnt;
    logic [IDXW-1:0]         lsz_idx;
    logic                    wrap;

    modport master (
        output enable, clear, dv_we, dv_dim, dv_idx, dv_data,
        input  rng_out, cnt, lsz_idx, wrap
    );

    modport slave (
        input  enable, clear, dv_we, dv_dim, dv_idx, dv_data,
        output rng_out, cnt, lsz_idx, wrap
    );
endinterface

// File: rtl/sobol_rng_nd.sv
// Multi-dimension Sobol point generator: shared index counter, least-significant-zero
// scan, and per-dimension XOR update with run-time loadable direction vectors.
module sobol_rng_nd #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NDIM  = 2
) (
    input logic           clk,
    input logic           rst_n,
    sobol_rng_nd_if.slave bus
);
    localparam int unsigned IDXW = $clog2(WIDTH);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rng_q [NDIM];
    logic [WIDTH-1:0] rng_d [NDIM];
    logic [WIDTH-1:0] v_q   [NDIM][WIDTH];
    logic             wrap_q, wrap_d;
    logic [IDXW-1:0]  lsz;
    logic             at_end;
    logic             dv_hit;

    // Scan from the top down so the lowest zero position is the last one written.
    always_comb begin
        lsz = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!cnt_q[k]) lsz = IDXW'(k);
        end
    end

    assign at_end = &cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        for (int d = 0; d < NDIM; d++) rng_d[d] = rng_q[d];
        if (bus.clear) begin
            cnt_d = '0;
            for (int d = 0; d < NDIM; d++) rng_d[d] = '0;
        end else if (bus.enable) begin
            if (at_end) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
                for (int d = 0; d < NDIM; d++) rng_d[d] = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                for (int d = 0; d < NDIM; d++) rng_d[d] = rng_q[d] ^ v_q[d][lsz];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            for (int d = 0; d < NDIM; d++) rng_q[d] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            for (int d = 0; d < NDIM; d++) rng_q[d] <= rng_d[d];
        end
    end

    // Out-of-range dimension or index is dropped rather than aliased.
    assign dv_hit = bus.dv_we && (32'(bus.dv_dim) < NDIM) && (32'(bus.dv_idx) < WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDIM; d++) begin
                for (int k = 0; k < WIDTH; k++) begin
                    v_q[d][k] <= WIDTH'(1) << (WIDTH - 1 - k);
                end
            end
        end else if (dv_hit) begin
            v_q[bus.dv_dim][bus.dv_idx] <= bus.dv_data;
        end
    end

    for (genvar d = 0; d < NDIM; d++) begin : g_out
        assign bus.rng_out[d*WIDTH +: WIDTH] = rng_q[d];
    end

    assign bus.cnt     = cnt_q;
    assign bus.lsz_idx = lsz;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_sobol_rng_nd.sv
// Directed bench for sobol_rng_nd: one 4-bit/2-dim instance for the detailed sequence
// checks, plus 8-bit/3-dim and 6-bit/1-dim instances for full-period and range checks.
module tb_sobol_rng_nd;
    logic clk;
    logic rst_n;

    int unsigned n_vec;
    int unsigned n_bad;

    sobol_rng_nd_if #(.WIDTH(4), .NDIM(2)) ia ();
    sobol_rng_nd_if #(.WIDTH(8), .NDIM(3)) ib ();
    sobol_rng_nd_if #(.WIDTH(6), .NDIM(1)) ic ();

    sobol_rng_nd #(.WIDTH(4), .NDIM(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    sobol_rng_nd #(.WIDTH(8), .NDIM(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    sobol_rng_nd #(.WIDTH(6), .NDIM(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] vdc     [17] = '{0, 8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1, 0};
    logic [1:0] lsz_tab [16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 0};
    logic [3:0] dl      [4]  = '{8, 12, 10, 15};
    logic [3:0] dl_exp  [5]  = '{0, 8, 4, 12, 6};
    logic [255:0] seen;
    int wraps;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Default vectors give bit-reversed Gray code of the step count.
    function automatic logic [15:0] vdc_ref(input int w, input int n);
        logic [31:0] g;
        logic [15:0] r;
        g = 32'(n ^ (n >> 1));
        r = '0;
        for (int k = 0; k < w; k++) r[w-1-k] = g[k];
        return r;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        {ia.enable, ia.clear, ia.dv_we, ia.dv_dim, ia.dv_idx, ia.dv_data} = '0;
        {ib.enable, ib.clear, ib.dv_we, ib.dv_dim, ib.dv_idx, ib.dv_data} = '0;
        {ic.enable, ic.clear, ic.dv_we, ic.dv_dim, ic.dv_idx, ic.dv_data} = '0;

        rst_n = 1'b0;
        #2;
        check("rst_rng", 64'(ia.rng_out), 64'd0);
        check("rst_cnt", 64'(ia.cnt), 64'd0);
        check("rst_wrap", 64'(ia.wrap), 64'd0);
        check("rst_lsz", 64'(ia.lsz_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Van der Corput period on both default dimensions
        ia.enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check($sformatf("vdc_d0_%0d", i), 64'(ia.rng_out[3:0]), 64'(vdc[i]));
            check($sformatf("vdc_d1_%0d", i), 64'(ia.rng_out[7:4]), 64'(vdc[i]));
            check($sformatf("vdc_wrap_%0d", i), 64'(ia.wrap), 64'(i == 16));
            if (i < 16) check($sformatf("vdc_lsz_%0d", i), 64'(ia.lsz_idx), 64'(lsz_tab[i]));
        end
        ia.enable = 1'b0;
        @(negedge clk);
        check("wrap_drop", 64'(ia.wrap), 64'd0);
        check("idle_cnt0", 64'(ia.cnt), 64'd0);

        // Load dimension 1, then step four points
        for (int k = 0; k < 4; k++) begin
            ia.dv_we = 1'b1; ia.dv_dim = 1'b1; ia.dv_idx = 2'(k); ia.dv_data = dl[k];
            @(negedge clk);
        end
        ia.dv_we  = 1'b0;
        ia.enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("load_d0_%0d", i), 64'(ia.rng_out[3:0]), 64'(vdc[i]));
            check($sformatf("load_d1_%0d", i), 64'(ia.rng_out[7:4]), 64'(dl_exp[i]));
        end
        ia.enable = 1'b0;
        @(negedge clk);
        check("hold_cnt", 64'(ia.cnt), 64'd4);
        check("hold_rng", 64'(ia.rng_out), 64'h66);
        ia.enable = 1'b1;
        @(negedge clk);
        check("step5_cnt", 64'(ia.cnt), 64'd5);
        check("step5_rng", 64'(ia.rng_out), 64'hEE);

        // Clear beats enable
        ia.clear = 1'b1;
        @(negedge clk);
        ia.clear = 1'b0; ia.enable = 1'b0;
        check("clr_cnt", 64'(ia.cnt), 64'd0);
        check("clr_rng", 64'(ia.rng_out), 64'd0);
        check("clr_wrap", 64'(ia.wrap), 64'd0);

        // Write during clear still lands
        ia.clear = 1'b1; ia.dv_we = 1'b1; ia.dv_dim = 1'b1; ia.dv_idx = 2'd0; ia.dv_data = 4'd3;
        @(negedge clk);
        ia.clear = 1'b0;

        // Write/step collision on V[0][0]: step uses the old vector
        ia.dv_dim = 1'b0; ia.dv_idx = 2'd0; ia.dv_data = 4'd1; ia.enable = 1'b1;
        @(negedge clk);
        ia.dv_we = 1'b0;
        check("coll_d0_1", 64'(ia.rng_out[3:0]), 64'd8);
        check("clrwr_d1_1", 64'(ia.rng_out[7:4]), 64'd3);
        @(negedge clk);
        check("coll_d0_2", 64'(ia.rng_out[3:0]), 64'd12);
        check("clrwr_d1_2", 64'(ia.rng_out[7:4]), 64'd15);
        @(negedge clk);
        check("coll_d0_3", 64'(ia.rng_out[3:0]), 64'd13);
        check("clrwr_d1_3", 64'(ia.rng_out[7:4]), 64'd12);

        // Async reset between edges at cnt=9
        repeat (6) @(negedge clk);
        ia.enable = 1'b0;
        check("pre_rst_cnt", 64'(ia.cnt), 64'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cnt", 64'(ia.cnt), 64'd0);
        check("arst_rng", 64'(ia.rng_out), 64'd0);
        check("arst_wrap", 64'(ia.wrap), 64'd0);
        check("arst_lsz", 64'(ia.lsz_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ia.enable = 1'b1;
        @(negedge clk);
        ia.enable = 1'b0;
        check("post_rst_cnt", 64'(ia.cnt), 64'd1);
        check("post_rst_rng", 64'(ia.rng_out), 64'h88);

        // 8-bit, 3 dims: out-of-range dimension writes, then one full period
        ib.dv_we = 1'b1; ib.dv_dim = 2'd3; ib.dv_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            ib.dv_idx = 3'(k);
            @(negedge clk);
        end
        ib.dv_we = 1'b0;
        check("b_start", 64'(ib.rng_out), 64'd0);
        seen  = '0;
        wraps = 0;
        ib.enable = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("b_d%0d_%0d", d, i), 64'(ib.rng_out[d*8 +: 8]),
                      64'(vdc_ref(8, i % 256)));
            end
            check($sformatf("b_wrap_%0d", i), 64'(ib.wrap), 64'(i == 256));
            seen[ib.rng_out[7:0]] = 1'b1;
            if (ib.wrap) wraps++;
        end
        ib.enable = 1'b0;
        check("b_distinct", 64'($countones(seen)), 64'd256);
        check("b_wraps", 64'(wraps), 64'd1);

        // 6-bit, 1 dim: out-of-range index and dimension writes, then one full period
        ic.dv_we = 1'b1; ic.dv_data = 6'h3F;
        ic.dv_dim = 1'b0; ic.dv_idx = 3'd6;
        @(negedge clk);
        ic.dv_idx = 3'd7;
        @(negedge clk);
        ic.dv_dim = 1'b1; ic.dv_idx = 3'd0;
        @(negedge clk);
        ic.dv_we  = 1'b0;
        ic.enable = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            check($sformatf("c_pt_%0d", i), 64'(ic.rng_out), 64'(vdc_ref(6, i % 64)));
            check($sformatf("c_wrap_%0d", i), 64'(ic.wrap), 64'(i == 64));
        end
        ic.enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sobol_rng_nd.md
# sobol_rng_nd

Parametrised multi-dimension Sobol sequence generator for the stochastic-computing bitstream path. It keeps a shared binary index counter and computes the least-significant-zero position of that counter for any width. It then updates one registered Sobol point per dimension by XOR with a run-time-loadable direction vector. It feeds the comparators of the SNG stage and replaces the fixed-width, macro-selected index-decode path.

## Interface
- `WIDTH`, 8: bits per Sobol point and of the index counter; legal 2..16.
- `NDIM`, 2: number of independent dimensions (output channels); legal 1..8.
- `IDXW`, `$clog2(WIDTH)`: width of the LSZ index; derived, not overridden.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: advance the sequence by one point this cycle.
- `clear` input 1: synchronous restart of the sequence; has priority over `enable`.
- `dv_we` input 1: direction-vector write strobe.
- `dv_dim` input `$clog2(NDIM)` (min 1): dimension being written.
- `dv_idx` input IDXW: direction-vector index being written (0..WIDTH-1).
- `dv_data` input WIDTH: direction-vector value.
- `rng_out` output NDIM*WIDTH: current point; dimension d occupies bits [d*WIDTH +: WIDTH].
- `cnt` output WIDTH: current sequence index n.
- `lsz_idx` output IDXW: least-significant-zero position of `cnt`; combinational from `cnt`.
- `wrap` output 1: registered one-cycle pulse when the sequence wraps to point 0.

## Operation
- State: index counter `cnt`, registered `rng_out`, and the direction-vector array `V[NDIM][WIDTH]` of WIDTH-bit registers.
- Reset (`rst_n`=0): `cnt`=0, `rng_out`=0, `wrap`=0.
  - Every dimension is loaded with van der Corput vectors: `V[d][k] = 1 << (WIDTH-1-k)`.
- LSZ: `lsz_idx` is the lowest bit position k where `cnt[k]`=0.
  - It is a generic priority scan, valid for any WIDTH.
  - When `cnt` is all ones (no zero), `lsz_idx`=0, and that value is not used for an update.
- Step, when `enable`=1, `clear`=0 and `cnt` ≠ all-ones:
  - `rng_out[d] <= rng_out[d] ^ V[d][lsz_idx]` for every d.
  - `cnt <= cnt+1`.
  - `wrap <= 0`.
- Wrap, when `enable`=1, `clear`=0 and `cnt` = all-ones (2^WIDTH-1):
  - `cnt <= 0`, `rng_out <= 0`, `wrap <= 1`.
  - Each full period is exactly 2^WIDTH points, starting at 0.
- Clear, when `clear`=1:
  - `cnt <= 0`, `rng_out <= 0`, `wrap <= 0`, regardless of `enable`.
  - Direction vectors are untouched.
- Idle, when `enable`=0 and `clear`=0: all state holds and `wrap <= 0`.
- Direction-vector write, when `dv_we`=1: `V[dv_dim][dv_idx] <= dv_data`.
  - Out-of-range `dv_dim` (≥NDIM) or `dv_idx` (≥WIDTH) is ignored with no side effects.
- Write and step in the same cycle: the step uses the old vector; the new value applies from the next step.
- Writes are independent of `clear` and `enable`; a write during `clear` still takes effect.

## Timing
- Update latency is 1 cycle: a step requested at edge t is visible on `rng_out`/`cnt` after edge t.
- `lsz_idx` is combinational from `cnt` and is valid in the same cycle as `cnt`.
- `wrap` is high for exactly the one cycle in which `cnt`=0 after a wrap step.
- Throughput is one point per cycle with `enable` held high; there are no bubbles at wrap.
- Reset mid-sequence: outputs go to their reset values immediately (asynchronously), and vector RAM returns to defaults.
  - On release the sequence restarts at point 0 with the first enabled edge.
- Critical path: LSZ scan (depth O(WIDTH)), then WIDTH:1 vector mux, then XOR; it must close at the SNG clock for WIDTH=16.

## Test plan
- Van der Corput sequence: WIDTH=4, defaults, `enable` high for 16 cycles after reset.
  - `rng_out[0]` must be 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1 and then 0.
  - `wrap`=1 only on the cycle showing the final 0.
  - `lsz_idx` sequence must be 0,1,0,2,0,1,0,3,...
- Dimension load: WIDTH=4, write `V[1]`={8,12,10,15} (idx0..3), then enable for 4 cycles.
  - `rng_out[1]` must be 0,8,4,12,6.
  - `rng_out[0]` must be unaffected: 0,8,12,4,6.
- Enable gaps and clear: toggle `enable` randomly and check each point against a reference model.
  - Assert `clear` together with `enable` at `cnt`=5: `cnt`=0, `rng_out`=0 next cycle, `wrap`=0.
- Write/step collision: with `dv_we` on `V[0][0]` with `dv_data`=1 and `enable` in the same cycle at `cnt`=0.
  - `rng_out[0]` must be 8 (old vector).
  - The step at `cnt`=2 then uses 1.
- Async reset mid-run: drop `rst_n` between edges at `cnt`=9.
  - All outputs must be 0 without waiting for a clock edge.
  - After release, a previously written vector must be back at its default.
- Parameter sweep: WIDTH ∈ {2,8,16}, NDIM ∈ {1,3}.
  - Full period produces 2^WIDTH distinct values per dimension and exactly one `wrap` per period.
  - Out-of-range `dv_dim`/`dv_idx` writes change nothing.
